// File: rtl/eth_pkg.sv
// Ethernet framing constants and deframer state encoding shared by the rx and tx paths.
package eth_pkg;
  localparam logic [7:0]  ETH_PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  ETH_SFD           = 8'hD5;
  localparam int          MAC_OCTETS        = 6;
  localparam int          ETHERTYPE_OCTETS  = 2;
  localparam int          FCS_OCTETS        = 4;
  localparam logic [31:0] ETH_CRC_POLY      = 32'hEDB88320;
  localparam logic [31:0] ETH_CRC_RESIDUE   = 32'hDEBB20E3;
  localparam logic [31:0] ETH_CRC_INIT      = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    ST_PREAMBLE,
    ST_DST,
    ST_SRC,
    ST_ETYPE,
    ST_PAYLOAD,
    ST_DROP
  } deframer_state_t;
endpackage

// File: rtl/crc32_byte.sv
// Combinational reflected CRC-32 update by one byte (LSB-first), no final inversion.
module crc32_byte
  import eth_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);
  logic [31:0] c;

  always_comb begin
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ ETH_CRC_POLY) : (c >> 1);
    end
    crc_next = c;
  end
endmodule

// File: rtl/eth_deframer.sv
// Byte-wide Ethernet deframer: strips preamble/SFD/header/FCS, forwards payload delayed by a 4-byte hold line.
// Output beats are combinational with the input; output stall holds the input (no skid).
module eth_deframer
  import eth_pkg::*;
#(
  parameter bit CHECK_CRC = 1'b1
) (
  input  logic        clk,
  input  logic        sreset,
  output logic        in_axis_tready,
  input  logic        in_axis_tvalid,
  input  logic        in_axis_tlast,
  input  logic [7:0]  in_axis_tdata,
  input  logic        out_axis_tready,
  output logic        out_axis_tvalid,
  output logic        out_axis_tlast,
  output logic        out_axis_tuser,
  output logic [7:0]  out_axis_tdata,
  output logic [47:0] dst_mac,
  output logic [47:0] src_mac,
  output logic [15:0] ethertype,
  output logic        hdr_valid,
  output logic        frame_drop
);
  deframer_state_t state;
  logic [2:0]      cnt;
  logic [2:0]      fill;
  logic [7:0]      hold [FCS_OCTETS];
  logic [31:0]     crc;
  logic [31:0]     crc_nxt;
  logic            line_full;
  logic            acc;

  crc32_byte u_crc (
    .crc      (crc),
    .data     (in_axis_tdata),
    .crc_next (crc_nxt)
  );

  assign line_full       = (state == ST_PAYLOAD) && (fill == 3'(FCS_OCTETS));
  assign in_axis_tready  = line_full ? out_axis_tready : 1'b1;
  assign acc             = in_axis_tvalid && in_axis_tready;
  assign out_axis_tvalid = line_full && in_axis_tvalid;
  assign out_axis_tdata  = line_full ? hold[0] : 8'h00;
  assign out_axis_tlast  = out_axis_tvalid && in_axis_tlast;
  // The running CRC over header+payload+FCS lands on the fixed residue for a good frame.
  assign out_axis_tuser  = CHECK_CRC && out_axis_tlast && (crc_nxt != ETH_CRC_RESIDUE);
  assign hdr_valid       = !sreset && acc && !in_axis_tlast && (state == ST_ETYPE) &&
                           (cnt == 3'(ETHERTYPE_OCTETS - 1));
  // Any frame ending other than through a full hold line is a discard.
  assign frame_drop      = !sreset && acc && in_axis_tlast && !line_full;

  always_ff @(posedge clk) begin
    if (sreset) begin
      state     <= ST_PREAMBLE;
      cnt       <= '0;
      fill      <= '0;
      crc       <= ETH_CRC_INIT;
      dst_mac   <= '0;
      src_mac   <= '0;
      ethertype <= '0;
      for (int i = 0; i < FCS_OCTETS; i++) hold[i] <= '0;
    end else if (acc) begin
      case (state)
        ST_PREAMBLE: begin
          if (in_axis_tlast) begin
            state <= ST_PREAMBLE;
          end else if (in_axis_tdata == ETH_SFD) begin
            state <= ST_DST;
            cnt   <= '0;
            crc   <= ETH_CRC_INIT;
          end else if (in_axis_tdata != ETH_PREAMBLE_BYTE) begin
            state <= ST_DROP;
          end
        end
        ST_DST: begin
          dst_mac <= {dst_mac[39:0], in_axis_tdata};
          crc     <= crc_nxt;
          cnt     <= cnt + 3'd1;
          if (in_axis_tlast) state <= ST_PREAMBLE;
          else if (cnt == 3'(MAC_OCTETS - 1)) begin
            state <= ST_SRC;
            cnt   <= '0;
          end
        end
        ST_SRC: begin
          src_mac <= {src_mac[39:0], in_axis_tdata};
          crc     <= crc_nxt;
          cnt     <= cnt + 3'd1;
          if (in_axis_tlast) state <= ST_PREAMBLE;
          else if (cnt == 3'(MAC_OCTETS - 1)) begin
            state <= ST_ETYPE;
            cnt   <= '0;
          end
        end
        ST_ETYPE: begin
          ethertype <= {ethertype[7:0], in_axis_tdata};
          crc       <= crc_nxt;
          cnt       <= cnt + 3'd1;
          if (in_axis_tlast) state <= ST_PREAMBLE;
          else if (cnt == 3'(ETHERTYPE_OCTETS - 1)) begin
            state <= ST_PAYLOAD;
            fill  <= '0;
          end
        end
        ST_PAYLOAD: begin
          crc <= crc_nxt;
          for (int i = 0; i < FCS_OCTETS - 1; i++) hold[i] <= hold[i + 1];
          hold[FCS_OCTETS-1] <= in_axis_tdata;
          if (!line_full) fill <= fill + 3'd1;
          if (in_axis_tlast) begin
            state <= ST_PREAMBLE;
            fill  <= '0;
          end
        end
        ST_DROP: begin
          if (in_axis_tlast) state <= ST_PREAMBLE;
        end
        default: state <= ST_PREAMBLE;
      endcase
    end
  end
endmodule

// File: doc/eth_deframer.md
Name: eth_deframer

Overview:
- Receive-side counterpart of the Ethernet framer. Consumes a byte-wide AXI Stream frame from the PHY/MAC interface: preamble, SFD, destination MAC, source MAC, ethertype, payload, FCS.
- Strips the preamble and SFD, captures the header fields into registers, and forwards only the payload on an output AXI Stream.
- Removes the 4-byte FCS, checks CRC-32, and flags bad frames on the last payload beat.

Parameters:
- CHECK_CRC, 1, when 0 the CRC is not computed and out_axis_tuser is tied 0.
- FCS_OCTETS, 4 (localparam), length of the trailing FCS.

Ports:
- clk  in  1  sole clock.
- sreset  in  1  synchronous reset, active-high.
- in_axis_tready  out  1  input handshake.
- in_axis_tvalid  in  1  input byte valid.
- in_axis_tlast  in  1  last byte of the frame, which is the final FCS byte.
- in_axis_tdata  in  8  input byte.
- out_axis_tready  in  1  payload sink ready.
- out_axis_tvalid  out  1  payload byte valid.
- out_axis_tlast  out  1  last payload byte.
- out_axis_tuser  out  1  CRC error; meaningful only with tlast.
- out_axis_tdata  out  8  payload byte.
- dst_mac  out  48  captured destination MAC; first received byte is in [47:40].
- src_mac  out  48  captured source MAC, MSB-first.
- ethertype  out  16  captured ethertype, MSB-first.
- hdr_valid  out  1  1-cycle pulse on the cycle the second ethertype byte is accepted.
- frame_drop  out  1  1-cycle pulse when a frame is discarded.

Behaviour:
- Reset values: all outputs 0 (including tvalid, tlast, tuser, header registers, pulses). State is PREAMBLE, hold fill is 0, CRC register is 32'hFFFFFFFF.
- Handshakes:
  - A byte is accepted when in_axis_tvalid && in_axis_tready.
  - in_axis_tready = 1 in every state except PAYLOAD with fill==4, where it equals out_axis_tready.
- States:
  - PREAMBLE: 8'h55 stays; 8'hD5 -> DST; any other byte -> DROP. tlast in this state -> PREAMBLE plus frame_drop.
  - DST: 6 bytes shifted into dst_mac -> SRC.
  - SRC: 6 bytes into src_mac -> ETYPE.
  - ETYPE: 2 bytes into ethertype; hdr_valid pulses on the 2nd byte -> PAYLOAD.
  - PAYLOAD: described below.
  - DROP: consume bytes until tlast is accepted, then -> PREAMBLE.
- tlast accepted in DST, SRC or ETYPE -> frame_drop pulse, return to PREAMBLE. No output is produced for that frame.
- Header registers update only during capture. They hold their value otherwise, including after a drop.
- PAYLOAD uses a 4-byte hold line (fill 0..4) to delay output:
  - While fill<4, each accepted byte is pushed and fill increments. No output.
  - While fill==4, out_axis_tvalid = in_axis_tvalid and out_axis_tdata = oldest held byte; the beat is combinational with the input. On acceptance, the oldest byte leaves, the new byte is pushed, and out_axis_tlast = in_axis_tlast.
  - At tlast, the hold line contains exactly the FCS.
- tlast accepted in PAYLOAD while fill<4 (payload of 0 bytes or runt): frame_drop pulse, no output beats, state -> PREAMBLE.
- CRC:
  - Reflected polynomial 32'hEDB88320, init 32'hFFFFFFFF, updated per accepted byte from the first DST byte through the last FCS byte.
  - On the tlast beat the combinational next value is compared with residue 32'hDEBB20E3. Mismatch drives out_axis_tuser = 1 on that beat.
  - The CRC register reinitialises on SFD detection.
- End of frame: after the tlast beat the state returns to PREAMBLE, fill is cleared, and the next frame may start the following cycle.
- Output stall: stalling out_axis_tready holds the input (no skid). Data and state are unchanged while stalled.
- Reset mid-frame: immediate return to reset values. The partial frame is lost; no frame_drop pulse.
- Simultaneous events: hdr_valid and frame_drop never coincide.

Decomposition:
- Package eth_pkg holds:
  - constants ETH_PREAMBLE_BYTE 8'h55, ETH_SFD 8'hD5;
  - MAC_OCTETS 6, ETHERTYPE_OCTETS 2, FCS_OCTETS 4;
  - ETH_CRC_POLY 32'hEDB88320, ETH_CRC_RESIDUE 32'hDEBB20E3;
  - an enum type for the deframer states.
- One sub-module: crc32_byte, a combinational next-CRC from the current CRC and a data byte. The transmit-side FCS generator reuses it.

Test Plan:
- Good frame: 7x55, D5, dst 01_02_03_04_05_06, src 0A_0B_0C_0D_0E_0F, ethertype 0800, payload 00..2D (46 bytes), valid FCS -> 46 output beats 00..2D. tlast on 2D, tuser 0. hdr_valid once; dst_mac=48'h010203040506, ethertype=16'h0800.
- Same frame with one payload byte flipped -> identical beat count, tuser=1 on the last beat.
- Bad SFD: 7x55 then C5, 60 bytes, tlast -> no output, one frame_drop. An immediate good frame afterwards passes intact.
- Runts: tlast on the 4th dst byte, and separately a frame with 3 bytes after ethertype -> frame_drop each, no output.
- Random out_axis_tready (50%) and random in_axis_tvalid gaps on the good frame -> identical payload/tlast/tuser. in_axis_tready follows out_axis_tready during fill==4.
- sreset asserted on the 10th payload byte -> all outputs 0 next cycle. The following good frame is received correctly.
